// File: rtl/enclave_pkg.sv
// Shared encodings and sizes for the LWE enclave engine.
// Row layout helper used by the encrypt and decrypt datapaths.
package enclave_pkg;

   localparam int PLAINTEXT_MODULUS  = 64;
   localparam int PW                 = 6;
   localparam int CIPHERTEXT_MODULUS = 1024;
   localparam int CW                 = 10;
   localparam int DIMENSION          = 10;
   localparam int BIG_N              = 30;
   localparam int DATA_WIDTH         = 128;
   localparam int ADDR_WIDTH         = 10;
   localparam int DEPTH              = 1024;
   localparam int DIM_WIDTH          = 4;
   localparam int CNT_WIDTH          = 5;
   localparam int LANES              = DATA_WIDTH / 32;

   localparam logic [31:0] OPCODE_ADDR = 32'h3000_0000;
   localparam logic [31:0] OUTPUT_ADDR = 32'h1000_0000;

   localparam logic [31:0] OP_NOP = 32'd0;
   localparam logic [31:0] OP_ENC = 32'd1;
   localparam logic [31:0] OP_DEC = 32'd2;

   localparam logic [5:0] OFF_OPCODE    = 6'h00;
   localparam logic [5:0] OFF_STATUS    = 6'h04;
   localparam logic [5:0] OFF_MSG       = 6'h08;
   localparam logic [5:0] OFF_MASK      = 6'h0C;
   localparam logic [5:0] OFF_PTR       = 6'h10;
   localparam logic [5:0] OFF_LANE0     = 6'h14;
   localparam logic [5:0] OFF_LANE_LAST = OFF_LANE0 + 6'(4 * (LANES - 1));

   localparam logic [3:0] RES_CT_B = 4'(DIMENSION);
   localparam logic [3:0] RES_PT   = 4'd15;

   localparam logic [CW-1:0] ROUND_HALF =
      CW'(CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS));

   localparam logic [ADDR_WIDTH-1:0] ROW_S  = ADDR_WIDTH'(BIG_N);
   localparam logic [ADDR_WIDTH-1:0] ROW_CT = ADDR_WIDTH'(BIG_N + 1);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BIG_N - 1);
   localparam logic [DIM_WIDTH-1:0] J_LAST   = DIM_WIDTH'(DIMENSION - 1);
   localparam logic [DIM_WIDTH-1:0] J_B      = DIM_WIDTH'(DIMENSION);

   typedef enum logic [2:0] {
      IDLE,
      ENC_RD,
      ENC_ACC,
      ENC_FIN,
      DEC_RD_S,
      DEC_RD_C,
      DEC_MAC,
      DEC_FIN
   } state_e;

   typedef logic [DIMENSION-1:0][CW-1:0] coef_vec_t;

   function automatic logic [CW-1:0] row_coef(
      input logic [DATA_WIDTH-1:0] row,
      input logic [DIM_WIDTH-1:0]  idx
   );
      return row[idx*CW +: CW];
   endfunction

endpackage

// File: rtl/enclave_row_mem.sv
// Single-port synchronous row RAM, one-cycle read latency.
// Read-during-write returns the previous contents.
module enclave_row_mem
   import enclave_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/enclave_top.sv
// Wishbone-slave LWE engine: row loading, encrypt subset-sum,
// decrypt inner product with rounding, and result read-back.
module enclave_top
   import enclave_pkg::*;
(
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o
);

   state_e                state_q, state_d;
   logic                  ack_q, ack_d;
   logic [31:0]           dat_o_q, dat_o_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic [PW-1:0]         msg_q, msg_d;
   logic [BIG_N-1:0]      mask_q, mask_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] stage_q, stage_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DIM_WIDTH-1:0]  j_q, j_d;
   coef_vec_t             ct_a_q, ct_a_d;
   logic [CW-1:0]         ct_b_q, ct_b_d;
   logic [PW-1:0]         pt_q, pt_d;
   coef_vec_t             s_q, s_d;
   logic [CW-1:0]         ct_b_in_q, ct_b_in_d;
   logic [CW-1:0]         sum_q, sum_d;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  wb_req, wr, rd;
   logic                  in_ctrl, in_out, busy;
   logic [5:0]            off;
   logic [3:0]            res_k;
   logic [1:0]            lane;
   logic [CW-1:0]         d_diff, d_round;
   logic                  in_unused;

   enclave_row_mem u_mem (
      .clk   (wb_clk_i),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign wb_req  = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign wr      = wb_req & wbs_we_i;
   assign rd      = wb_req & ~wbs_we_i;
   assign in_ctrl = wbs_adr_i[31:6] == OPCODE_ADDR[31:6];
   assign in_out  = wbs_adr_i[31:6] == OUTPUT_ADDR[31:6];
   assign off     = wbs_adr_i[5:0];
   assign res_k   = wbs_adr_i[5:2];
   assign busy    = state_q != IDLE;

   // The b field of the secret row and spare row bits carry nothing.
   assign in_unused = ^{wbs_sel_i,
                        mem_rdata[DATA_WIDTH-1:(DIMENSION+1)*CW]};

   always_comb begin
      state_d   = state_q;
      ack_d     = wb_req;
      dat_o_d   = '0;
      err_d     = err_q;
      done_d    = done_q;
      msg_d     = msg_q;
      mask_d    = mask_q;
      ptr_d     = ptr_q;
      stage_d   = stage_q;
      cnt_d     = cnt_q;
      j_d       = j_q;
      ct_a_d    = ct_a_q;
      ct_b_d    = ct_b_q;
      pt_d      = pt_q;
      s_d       = s_q;
      ct_b_in_d = ct_b_in_q;
      sum_d     = sum_q;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = {wbs_dat_i, stage_q[DATA_WIDTH-33:0]};
      lane      = '0;
      d_diff    = '0;
      d_round   = '0;

      unique case (state_q)
         IDLE: ;
         ENC_RD: begin
            mem_addr = '0;
            cnt_d    = '0;
            state_d  = ENC_ACC;
         end
         ENC_ACC: begin
            mem_addr = ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
            if (mask_q[cnt_q]) begin
               for (int k = 0; k < DIMENSION; k++)
                  ct_a_d[k] = ct_a_q[k]
                            + row_coef(mem_rdata, DIM_WIDTH'(k));
               ct_b_d = ct_b_q + row_coef(mem_rdata, J_B);
            end
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_LAST) state_d = ENC_FIN;
         end
         ENC_FIN: begin
            ct_b_d  = ct_b_q + {msg_q, {(CW-PW){1'b0}}};
            done_d  = 1'b1;
            state_d = IDLE;
         end
         DEC_RD_S: begin
            mem_addr = ROW_S;
            state_d  = DEC_RD_C;
         end
         DEC_RD_C: begin
            mem_addr = ROW_CT;
            s_d      = mem_rdata[DIMENSION*CW-1:0];
            j_d      = '0;
            state_d  = DEC_MAC;
         end
         // Address stays on the ciphertext row so a[j] is read live.
         DEC_MAC: begin
            mem_addr = ROW_CT;
            sum_d    = sum_q + row_coef(mem_rdata, j_q) * s_q[j_q];
            if (j_q == '0) ct_b_in_d = row_coef(mem_rdata, J_B);
            j_d = j_q + DIM_WIDTH'(1);
            if (j_q == J_LAST) state_d = DEC_FIN;
         end
         DEC_FIN: begin
            d_diff  = ct_b_in_q - sum_q;
            d_round = d_diff + ROUND_HALF;
            pt_d    = d_round[CW-1 -: PW];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rd && in_ctrl) begin
         unique case (off)
            OFF_STATUS: dat_o_d = {29'b0, err_q, done_q, busy};
            OFF_MSG:    dat_o_d = 32'(msg_q);
            OFF_MASK:   dat_o_d = 32'(mask_q);
            OFF_PTR:    dat_o_d = 32'(ptr_q);
            default:    dat_o_d = '0;
         endcase
      end else if (rd && in_out) begin
         if (res_k < RES_CT_B)       dat_o_d = 32'(ct_a_q[res_k]);
         else if (res_k == RES_CT_B) dat_o_d = 32'(ct_b_q);
         else if (res_k == RES_PT)   dat_o_d = 32'(pt_q);
      end

      if (wr && in_ctrl) begin
         unique case (off)
            OFF_OPCODE: begin
               if (!busy) begin
                  unique case (wbs_dat_i)
                     OP_NOP: ;
                     OP_ENC: begin
                        state_d = ENC_RD;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        ct_a_d  = '0;
                        ct_b_d  = '0;
                     end
                     OP_DEC: begin
                        state_d = DEC_RD_S;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        pt_d    = '0;
                        sum_d   = '0;
                        j_d     = '0;
                     end
                     default: err_d = 1'b1;
                  endcase
               end
            end
            OFF_MSG:  msg_d  = wbs_dat_i[PW-1:0];
            OFF_MASK: mask_d = wbs_dat_i[BIG_N-1:0];
            OFF_PTR:  ptr_d  = wbs_dat_i[ADDR_WIDTH-1:0];
            default: begin
               if (off >= OFF_LANE0 && off <= OFF_LANE_LAST
                   && off[1:0] == 2'b00) begin
                  lane = 2'((off - OFF_LANE0) >> 2);
                  stage_d[lane*32 +: 32] = wbs_dat_i;
                  if (off == OFF_LANE_LAST) begin
                     mem_we   = 1'b1;
                     mem_addr = ptr_q;
                     ptr_d    = ptr_q + ADDR_WIDTH'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         dat_o_q   <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         msg_q     <= '0;
         mask_q    <= '0;
         ptr_q     <= '0;
         stage_q   <= '0;
         cnt_q     <= '0;
         j_q       <= '0;
         ct_a_q    <= '0;
         ct_b_q    <= '0;
         pt_q      <= '0;
         s_q       <= '0;
         ct_b_in_q <= '0;
         sum_q     <= '0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         dat_o_q   <= dat_o_d;
         err_q     <= err_d;
         done_q    <= done_d;
         msg_q     <= msg_d;
         mask_q    <= mask_d;
         ptr_q     <= ptr_d;
         stage_q   <= stage_d;
         cnt_q     <= cnt_d;
         j_q       <= j_d;
         ct_a_q    <= ct_a_d;
         ct_b_q    <= ct_b_d;
         pt_q      <= pt_d;
         s_q       <= s_d;
         ct_b_in_q <= ct_b_in_d;
         sum_q     <= sum_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_o_q;

endmodule

// File: tb/tb_enclave_top.sv
// Scoreboard bench for enclave_top: bus reads pop expected words
// produced by a small LWE reference model kept in the bench.
module tb_enclave_top;

   localparam logic [31:0] OPC  = 32'h3000_0000;
   localparam logic [31:0] ST   = 32'h3000_0004;
   localparam logic [31:0] MSG  = 32'h3000_0008;
   localparam logic [31:0] MASK = 32'h3000_000C;
   localparam logic [31:0] PTR  = 32'h3000_0010;
   localparam logic [31:0] LN0  = 32'h3000_0014;
   localparam logic [31:0] OUT  = 32'h1000_0000;
   localparam logic [31:0] UNM  = 32'h2000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] dat_i, adr;
   logic        ack;
   logic [31:0] dat_o;

   int total = 0;
   int bad   = 0;

   logic [31:0]  exp_q [$];
   string        tag_q [$];
   logic [127:0] rows_m [32];
   int           ptr_m;
   logic [29:0]  mask_m;
   logic [5:0]   msg_m;
   logic [9:0]   ea [10];
   logic [9:0]   eb;

   always #5 clk = ~clk;

   enclave_top dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat_i),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
      int n;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ack && n < 4);
      chk("ack_lat", n, 1);
      if (!w && exp_q.size() > 0)
         chk(tag_q.pop_front(), dat_o, exp_q.pop_front());
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      chk("ack_pulse", {31'b0, ack}, 32'd0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      xfer(1'b1, a, d);
   endtask

   task automatic rd(input string tag, input logic [31:0] a,
                     input logic [31:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      xfer(1'b0, a, 32'd0);
   endtask

   function automatic logic [127:0] mk_row(input logic [9:0] a,
                                           input logic [9:0] b);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < 10; j++) r[j*10 +: 10] = a;
      r[100 +: 10] = b;
      return r;
   endfunction

   task automatic set_ptr(input int p);
      wr(PTR, 32'(p));
      ptr_m = p;
   endtask

   task automatic write_row(input logic [127:0] r);
      for (int l = 0; l < 4; l++) wr(LN0 + 32'(4 * l), r[l*32 +: 32]);
      rows_m[ptr_m] = r;
      ptr_m++;
   endtask

   // Write opcode, then issue a status read whose request cycle is n
   // cycles after the opcode ack cycle.
   task automatic probe(input logic [31:0] op, input int n,
                        input logic [31:0] e, input string tag);
      wr(OPC, op);
      repeat (n - 1) @(posedge clk);
      rd(tag, ST, e);
   endtask

   task automatic model_enc();
      for (int k = 0; k < 10; k++) ea[k] = '0;
      eb = '0;
      for (int i = 0; i < 30; i++) begin
         if (mask_m[i]) begin
            for (int k = 0; k < 10; k++)
               ea[k] = ea[k] + rows_m[i][k*10 +: 10];
            eb = eb + rows_m[i][100 +: 10];
         end
      end
      eb = eb + {msg_m, 4'b0};
   endtask

   function automatic logic [31:0] model_pt();
      logic [9:0] sum, d, r;
      sum = '0;
      for (int j = 0; j < 10; j++)
         sum = sum + rows_m[30][j*10 +: 10] * rows_m[31][j*10 +: 10];
      d = rows_m[31][100 +: 10] - sum;
      r = d + 10'd8;
      return {26'b0, r[9:4]};
   endfunction

   task automatic check_enc(input string tag);
      model_enc();
      for (int k = 0; k < 10; k++)
         rd($sformatf("%s_a%0d", tag, k), OUT + 32'(4 * k), 32'(ea[k]));
      rd({tag, "_b"}, OUT + 32'd40, 32'(eb));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] r;
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      sel = 4'hF; adr = '0; dat_i = '0;
      ptr_m = 0; mask_m = '0; msg_m = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      rd("rst_status", ST, 0);
      rd("rst_ptr", PTR, 0);
      rd("rst_mask", MASK, 0);
      rd("rst_ctb", OUT + 32'd40, 0);
      rd("rst_pt", OUT + 32'd60, 0);
      rd("unmapped_rd", UNM, 0);
      wr(UNM, 32'hDEAD_BEEF);
      rd("unmapped_wr", UNM, 0);
      wr(OPC, 32'd5);
      rd("bad_opcode", ST, 4);

      set_ptr(0);
      write_row(mk_row(10'd1, 10'd5));
      rd("ptr_inc", PTR, 1);
      wr(MASK, 32'd1); mask_m = 30'd1;
      wr(MSG, 32'd3);  msg_m = 6'd3;
      rd("msg_rb", MSG, 3);
      rd("mask_rb", MASK, 1);
      probe(32'd1, 31, 32'd1, "enc_busy31");
      probe(32'd1, 32, 32'd2, "enc_done32");
      check_enc("enc_basic");

      wr(OPC, 32'd1);
      wr(OPC, 32'd1);
      wr(OPC, 32'd5);
      repeat (27) @(posedge clk);
      rd("busy_ignore", ST, 2);
      wr(OUT, 32'h3FF);
      check_enc("enc_ign");

      set_ptr(0);
      for (int i = 0; i < 30; i++) write_row(mk_row(10'd1023, 10'd1023));
      wr(MASK, 32'h3FFF_FFFF); mask_m = 30'h3FFF_FFFF;
      wr(MSG, 32'd0); msg_m = 6'd0;
      probe(32'd1, 32, 32'd2, "encw_done");
      check_enc("enc_wrap");

      set_ptr(30);
      write_row(mk_row(10'd1, 10'd0));
      write_row(mk_row(10'd2, 10'd71));
      probe(32'd2, 12, 32'd1, "dec_busy12");
      probe(32'd2, 13, 32'd2, "dec_done13");
      rd("dec_basic", OUT + 32'd60, model_pt());

      set_ptr(30);
      write_row(mk_row(10'd0, 10'd0));
      write_row(mk_row(10'd2, 10'd1023));
      probe(32'd2, 13, 32'd2, "decw_done");
      rd("dec_wrap", OUT + 32'd60, model_pt());
      set_ptr(31);
      write_row(mk_row(10'd2, 10'd135));
      probe(32'd2, 13, 32'd2, "dec8_done");
      rd("dec_eight", OUT + 32'd60, model_pt());

      for (int t = 0; t < 3; t++) begin
         set_ptr(30);
         for (int v = 0; v < 2; v++) begin
            r = '0;
            for (int j = 0; j < 11; j++)
               r[j*10 +: 10] = 10'($urandom_range(0, 1023));
            write_row(r);
         end
         probe(32'd2, 13, 32'd2, "decr_done");
         rd($sformatf("dec_rand%0d", t), OUT + 32'd60, model_pt());
      end

      wr(OPC, 32'd1);
      repeat (10) @(posedge clk);
      do_reset();
      rd("midrst_status", ST, 0);
      rd("midrst_a0", OUT, 0);
      rd("midrst_ctb", OUT + 32'd40, 0);
      rd("midrst_pt", OUT + 32'd60, 0);
      rd("midrst_ptr", PTR, 0);
      rd("midrst_mask", MASK, 0);
      rd("midrst_msg", MSG, 0);

      if (exp_q.size() != 0) chk("queue_left", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
